// File: rtl/adder.sv
// Registered WIDTH-bit adder: two-level carry-lookahead core (4-bit groups plus
// a group-level lookahead), with {cout, s} captured on each rising clk edge.
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  input  logic             clk,
  input  logic             rst
);

  localparam int NG = WIDTH / 4;

  // Carries into each bit of a 4-bit group, flattened from the group carry-in.
  function automatic logic [3:0] cla4_carries(input logic [3:0] g, input logic [3:0] p,
                                              input logic ci);
    logic [3:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  function automatic logic group_gen(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  function automatic logic group_prop(input logic [3:0] p);
    return p[3] & p[2] & p[1] & p[0];
  endfunction

  logic [WIDTH-1:0] g_s;
  logic [WIDTH-1:0] p_s;
  logic [WIDTH-1:0] c_s;
  logic [NG-1:0]    grp_g_s;
  logic [NG-1:0]    grp_p_s;
  logic [NG:0]      gc_s;
  logic [WIDTH-1:0] sum_s;
  logic             cout_s;

  assign g_s = a & b;
  assign p_s = a ^ b;

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    assign grp_g_s[gi]       = group_gen(g_s[4*gi +: 4], p_s[4*gi +: 4]);
    assign grp_p_s[gi]       = group_prop(p_s[4*gi +: 4]);
    assign c_s[4*gi +: 4]    = cla4_carries(g_s[4*gi +: 4], p_s[4*gi +: 4], gc_s[gi]);
  end

  // Second-level lookahead: every group carry-in is its own sum-of-products of
  // cin and the lower groups' G/P, so no carry ripples between groups.
  always_comb begin
    logic acc;
    logic run_p;
    gc_s    = {(NG + 1){1'b0}};
    gc_s[0] = cin;
    for (int j = 1; j <= NG; j++) begin
      acc   = 1'b0;
      run_p = 1'b1;
      for (int k = j - 1; k >= 0; k--) begin
        acc   = acc | (run_p & grp_g_s[k]);
        run_p = run_p & grp_p_s[k];
      end
      gc_s[j] = acc | (run_p & cin);
    end
  end

  assign sum_s  = p_s ^ c_s;
  assign cout_s = gc_s[NG];

  // Output pipeline stage; reset wins over the add in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s    <= {WIDTH{1'b0}};
      cout <= 1'b0;
    end else begin
      s    <= sum_s;
      cout <= cout_s;
    end
  end

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: directed table, multi-cycle sequences and a
// randomized run against a plain 33-bit arithmetic model.
module tb_adder;

  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic [31:0] s;
  logic        cout;
  logic        clk;
  logic        rst;

  int n_checks = 0;
  int n_fail   = 0;

  adder #(.WIDTH(32)) dut (
    .a    (a),
    .b    (b),
    .cin  (cin),
    .s    (s),
    .cout (cout),
    .clk  (clk),
    .rst  (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] exp_s;
    logic        exp_c;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] exp_s, input logic exp_c);
    n_checks++;
    if (s !== exp_s || cout !== exp_c) begin
      n_fail++;
      $display("FAIL %s: got s=%h cout=%b, expected s=%h cout=%b", name, s, cout, exp_s, exp_c);
    end
  endtask

  function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic c);
    return {1'b0, x} + {1'b0, y} + {32'd0, c};
  endfunction

  initial begin
    logic [32:0] golden;
    logic        r_rst;

    vecs[0] = '{"full_chain_cin", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
    vecs[1] = '{"all_ones",       32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[2] = '{"group0_carry",   32'h0000_000F, 32'h0000_0001, 1'b0, 32'h0000_0010, 1'b0};
    vecs[3] = '{"top_group",      32'h0FFF_FFFF, 32'h0000_0001, 1'b0, 32'h1000_0000, 1'b0};
    vecs[4] = '{"zero",           32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
    vecs[5] = '{"no_carry_mix",   32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0};
    vecs[6] = '{"alt_prop_cin",   32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'h0000_0000, 1'b1};
    vecs[7] = '{"mid_group",      32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0};

    // Reset sequence: reset dominates an add that would carry out.
    rst = 1'b1; a = 32'hFFFF_FFFF; b = 32'h0000_0001; cin = 1'b1;
    tick();
    check("reset_edge1", 32'h0000_0000, 1'b0);
    tick();
    check("reset_edge2", 32'h0000_0000, 1'b0);
    rst = 1'b0;
    tick();
    check("reset_release", 32'h0000_0001, 1'b1);

    // Signed boundary, then hold steady for 100 time units.
    a = 32'h7FFF_FFFF; b = 32'h0000_0001; cin = 1'b0;
    tick();
    check("signed_boundary", 32'h8000_0000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("signed_hold", 32'h8000_0000, 1'b0);
    end

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin;
      tick();
      check(vecs[i].name, vecs[i].exp_s, vecs[i].exp_c);
    end

    // Back-to-back operands: one-cycle latency, no bubbles, and input changes
    // between edges must not disturb the registered outputs.
    a = 32'd1; b = 32'd2; cin = 1'b0;
    tick();
    check("thru_1", 32'd3, 1'b0);
    a = 32'd3; b = 32'd4; cin = 1'b1;
    #1 check("thru_hold_1", 32'd3, 1'b0);
    @(negedge clk);
    check("thru_2", 32'd8, 1'b0);
    a = 32'h8000_0000; b = 32'h8000_0000; cin = 1'b0;
    #1 check("thru_hold_2", 32'd8, 1'b0);
    @(negedge clk);
    check("thru_3", 32'h0000_0000, 1'b1);

    // Randomized run with occasional reset.
    for (int i = 0; i < 1000; i++) begin
      a     = $urandom;
      b     = $urandom;
      cin   = 1'($urandom_range(1, 0));
      r_rst = ($urandom_range(99, 0) < 2);
      rst   = r_rst;
      golden = r_rst ? 33'd0 : model(a, b, cin);
      tick();
      check(r_rst ? "rand_reset" : "rand_sum", golden[31:0], golden[32]);
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
